// File: rtl/binary_search_4_bits.sv
// binary_search_4_bits: binary-search initiator that locates the value held by a
// magnitude-comparator responder (A = target, B = guess).
// Latency: 2 cycles per probe (CALC + at least one PROBE cycle); at most WIDTH+1 probes.
// Backpressure: PROBE holds guess/guess_valid until resp_valid is seen.
// Optional macro BINARY_SEARCH_TIMEOUT_EN: abort to ERR after TIMEOUT_CYCLES unanswered PROBE cycles.
module binary_search_4_bits #(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  input  logic             resp_valid,
  input  logic             resp_ma,
  input  logic             resp_me,
  input  logic             resp_ig,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       steps,
  output logic             error
);

  // steps is 3 bits wide, so WIDTH+1 probes must fit; the timeout needs at least one cycle.
  if (WIDTH < 1 || WIDTH > 6 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("binary_search_4_bits: WIDTH must be 1..6 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_PROBE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       steps_q, steps_d;

  // guess+1 keeps the carry so "guess+1 > hi" is exact; guess-1 is only used when guess != 0.
  logic [WIDTH:0]   guess_inc;
  logic [WIDTH-1:0] guess_dec;

`ifdef BINARY_SEARCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign guess_inc = {1'b0, guess_q} + (WIDTH+1)'(1);
  assign guess_dec = guess_q - WIDTH'(1);

  // Outputs are decoded from registers only: no input reaches an output combinationally.
  assign guess       = guess_q;
  assign guess_valid = (state_q == S_PROBE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign result      = result_q;
  assign steps       = steps_q;

  // Next-state and datapath decode for the search FSM.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
`ifdef BINARY_SEARCH_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = MAX_V;
          steps_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Midpoint computed one bit wider so lo+hi cannot wrap.
        guess_d = WIDTH'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
        state_d = S_PROBE;
`ifdef BINARY_SEARCH_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_PROBE: begin
        if (resp_valid) begin
          steps_d = steps_q + 3'd1;
          case ({resp_ma, resp_me, resp_ig})
            3'b001: begin
              result_d = guess_q;
              state_d  = S_DONE;
            end
            3'b100: begin
              // Target above guess: raise the floor, or fail if no room remains.
              if (guess_q == MAX_V) begin
                state_d = S_ERR;
              end else begin
                lo_d    = guess_inc[WIDTH-1:0];
                state_d = (guess_inc > {1'b0, hi_q}) ? S_ERR : S_CALC;
              end
            end
            3'b010: begin
              // Target below guess: lower the ceiling, or fail if no room remains.
              if (guess_q == '0) begin
                state_d = S_ERR;
              end else begin
                hi_d    = guess_dec;
                state_d = (guess_dec < lo_q) ? S_ERR : S_CALC;
              end
            end
            default: state_d = S_ERR;
          endcase
        end
`ifdef BINARY_SEARCH_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= MAX_V;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
    end
  end

`ifdef BINARY_SEARCH_TIMEOUT_EN
  // Unanswered-probe cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_binary_search_4_bits.sv
// Bench for binary_search_4_bits: randomized targets and answer latencies against an
// interval-halving reference model; targets are held doubled so half-integer values act
// as a consistent-but-lying responder.
module tb_binary_search_4_bits;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst, start, resp_valid, resp_ma, resp_me, resp_ig;
  logic [3:0] guess, result;
  logic       guess_valid, done, error;
  logic [2:0] steps;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model results
  int m_probes[$];
  int m_done;
  int m_steps;
  int m_last_result = 0;
  bit chk_final = 1'b0;

  always #5 clk = ~clk;

  binary_search_4_bits #(.WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .guess(guess), .guess_valid(guess_valid),
    .resp_valid(resp_valid), .resp_ma(resp_ma), .resp_me(resp_me), .resp_ig(resp_ig),
    .done(done), .result(result), .steps(steps), .error(error)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Search over [0,15] against target t2/2; an empty interval or a malformed first answer is an error.
  task automatic model_run(input int t2, input int bad);
    int lo, hi, g;
    m_probes.delete();
    lo = 0; hi = 15; m_done = 0; m_steps = 0;
    while (1) begin
      g = (lo + hi) / 2;
      m_probes.push_back(g);
      m_steps++;
      if (bad != 0 && m_steps == 1) break;
      if (t2 == 2 * g) begin
        m_done = 1;
        break;
      end else if (t2 > 2 * g) lo = g + 1;
      else hi = g - 1;
      if (lo > hi) break;
    end
  endtask

  // Final outcome must be held every cycle until the next start.
  always @(negedge clk) begin
    if (chk_final) begin
      check("hold_done", done, m_done);
      check("hold_error", error, (m_done == 0) ? 1 : 0);
      check("hold_steps", steps, m_steps);
      check("hold_result", result, m_last_result);
    end
  end

  task automatic run_search(input int t2, input int lat, input int bad);
    int L, g0, cnt, c;
    model_run(t2, bad);
    chk_final = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    check("after_start_flags", {done, error, guess_valid}, 0);
    for (int k = 0; k < m_probes.size(); k++) begin
      cnt = 0;
      while (!guess_valid && cnt < 8) begin
        step;
        cnt++;
      end
      check("gap_cycles", cnt, 1);
      if (!guess_valid) return;
      check("probe_guess", guess, m_probes[k]);
      g0 = guess;
      L = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      repeat (L) begin
        resp_valid = 1'b0;
        {resp_ma, resp_me, resp_ig} = 3'($urandom_range(0, 7));
        step;
      end
      check("probe_hold", guess_valid ? int'(guess) : -1, g0);
      c = t2 - 2 * m_probes[k];
      if (k == 0 && bad == 1) {resp_ma, resp_me, resp_ig} = 3'b110;
      else if (k == 0 && bad == 2) {resp_ma, resp_me, resp_ig} = 3'b000;
      else {resp_ma, resp_me, resp_ig} = {c > 0, c < 0, c == 0};
      resp_valid = 1'b1;
      step;
      resp_valid = 1'b0;
      {resp_ma, resp_me, resp_ig} = 3'b000;
    end
    if (m_done != 0) m_last_result = m_probes[$];
    check("final_done", done, m_done);
    check("final_error", error, (m_done == 0) ? 1 : 0);
    check("final_steps", steps, m_steps);
    check("final_result", result, m_last_result);
    check("final_gv", guess_valid, 0);
    chk_final = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t2, bad;
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0;
    resp_ma = 1'b0; resp_me = 1'b0; resp_ig = 1'b0;

    // Pin the model with hand-derived outcomes.
    model_run(22, 0);
    check("model_t11_steps", m_steps, 2);
    check("model_t11_p1", m_probes[1], 11);
    model_run(0, 0);
    check("model_t0_steps", m_steps, 4);
    check("model_t0_p3", m_probes[3], 0);
    model_run(13, 0);
    check("model_lie_done", m_done, 0);
    check("model_lie_steps", m_steps, 4);
    model_run(31, 0);
    check("model_top_steps", m_steps, 5);

    step; step;
    check("reset_outputs", {guess, guess_valid, done, result, steps, error}, 0);
    rst = 1'b0;
    step;
    check("idle_outputs", {guess, guess_valid, done, result, steps, error}, 0);

    run_search(22, 0, 0);   // target 11, same-cycle answers
    run_search(0, 3, 0);    // target 0, three-cycle latency
    run_search(30, -1, 0);  // target 15, worst case
    run_search(12, -1, 0);  // target 6, restart from DONE
    run_search(13, 1, 0);   // lying responder: interval empties
    run_search(22, 0, 1);   // both flags on first probe
    run_search(22, 2, 2);   // no flags on first probe
    run_search(-1, 0, 0);   // "less" at guess 0
    run_search(31, 0, 0);   // "greater" at guess 15

    // Reset during the second probe.
    chk_final = 1'b0;
    start = 1'b1; step; start = 1'b0;
    step;
    {resp_ma, resp_me, resp_ig} = 3'b100; resp_valid = 1'b1;
    step;
    resp_valid = 1'b0; {resp_ma, resp_me, resp_ig} = 3'b000;
    step;
    check("second_probe_gv", guess_valid, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    m_last_result = 0;
    check("midreset_outputs", {guess, guess_valid, done, result, steps, error}, 0);
    run_search(22, 0, 0);

    for (int i = 0; i < 40; i++) begin
      t2  = int'($urandom_range(0, 32)) - 1;
      bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_search(t2, -1, bad);
    end

    // Unanswered probe.
    chk_final = 1'b0;
    start = 1'b1; step; start = 1'b0;
`ifdef BINARY_SEARCH_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step;
      if (error) break;
      if (guess_valid) cnt++;
    end
    check("tmo_probe_cycles", cnt, TMO);
    check("tmo_error", error, 1);
    check("tmo_steps", steps, 0);
`else
    repeat (1000) step;
    check("no_tmo_waiting", {guess_valid, error}, 2);
`endif
    rst = 1'b1; step; rst = 1'b0;
    m_last_result = 0;
    check("final_reset", {guess_valid, done, error, steps}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
